// File: rtl/aww_types_pkg.sv
// Shared types for the pipeline control sequencer: stall vector layout,
// sequencer state encoding and stage bit positions.
package aww_types_pkg;

    typedef struct packed {
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } pipe_stall_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pctl_state_t;

    localparam int IFID  = 3;
    localparam int IDEX  = 2;
    localparam int EXMEM = 1;
    localparam int MEMWB = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] q_q;
    logic [CNT_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != {CNT_W{1'b1}})) begin
            q_d = q_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_ctrl_seq.sv
// Turns hazard-unit stall/flush commands into per-latch enables and clears,
// tracks per-stage valid bits, sequences the halt drain and keeps perf counters.
//
// state  | meaning
// RUN    | normal fetch and advance
// DRAIN  | halt seen in ID/EX; fetch stopped, older stages keep advancing
// HALTED | halt retired from MEM/WB; every latch frozen until RST
module pipe_ctrl_seq
    import aww_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             hz_pc_WEN,
    input  pipe_stall_t      hz_pipe_stall,
    input  logic             hz_ifid_FLUSH,
    input  logic             hz_idex_FLUSH,
    input  logic             hz_exmem_FLUSH,
    input  logic             hz_memwb_FLUSH,
    input  logic             fetch_valid,
    input  logic             idex_Halt,
    input  logic             memwb_Halt,
    output logic             pc_en,
    output logic [3:0]       stage_en,
    output logic [3:0]       stage_clr,
    output logic [3:0]       stage_valid,
    output logic             dp_halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    pctl_state_t state_q, state_d;
    logic [3:0]  valid_q, valid_d;
    logic        dp_halt_q, dp_halt_d;

    logic [3:0]  stall_v;
    logic [3:0]  flush_v;
    logic [3:0]  valid_in;
    logic        halt_go;
    logic        halt_done;
    logic        halted;
    logic        stall_inc;
    logic        flush_inc;
    logic        retire_inc;

    assign stall_v = hz_pipe_stall;
    assign flush_v = {hz_ifid_FLUSH, hz_idex_FLUSH, hz_exmem_FLUSH, hz_memwb_FLUSH};

    always_comb begin
        state_d   = state_q;
        dp_halt_d = dp_halt_q;
        halted    = (state_q == HALTED);
        // A halt being flushed in the same cycle is on the wrong path.
        halt_go   = idex_Halt & valid_q[IDEX] & ~hz_idex_FLUSH;
        halt_done = memwb_Halt & valid_q[MEMWB];

        case (state_q)
            RUN: begin
                if (halt_done) begin
                    state_d = HALTED;
                end else if (halt_go) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (halt_done) begin
                    state_d = HALTED;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase

        if (state_d == HALTED) begin
            dp_halt_d = 1'b1;
        end

        // Fetch stops in the very cycle the halt is recognised, not one later.
        pc_en     = hz_pc_WEN & (state_q == RUN) & ~halt_go;
        stage_en  = ~stall_v & {4{~halted}};
        stage_clr = flush_v & {4{~halted}};

        valid_in = {fetch_valid & pc_en & (state_q != DRAIN), valid_q[3:1]};
        valid_d  = valid_q;
        for (int i = 0; i < 4; i++) begin
            if (stage_clr[i]) begin
                valid_d[i] = 1'b0;
            end else if (stage_en[i]) begin
                valid_d[i] = valid_in[i];
            end
        end

        stall_inc  = (|stall_v) & (state_q == RUN);
        flush_inc  = (|flush_v) & ~halted;
        retire_inc = stage_en[MEMWB] & valid_q[MEMWB] & ~memwb_Halt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= RUN;
            valid_q   <= '0;
            dp_halt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            dp_halt_q <= dp_halt_d;
        end
    end

    assign stage_valid = valid_q;
    assign dp_halt     = dp_halt_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (CLK),
        .inc (stall_inc),
        .clr (RST),
        .q   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (CLK),
        .inc (flush_inc),
        .clr (RST),
        .q   (flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_retire_cnt (
        .clk (CLK),
        .inc (retire_inc),
        .clr (RST),
        .q   (retire_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Directed bench for pipe_ctrl_seq: reset, straight-line fill, load-use,
// halt drain, wrong-path halt and counter saturation (second instance, CNT_W=4).
module tb_pipe_ctrl_seq;

    logic       CLK = 1'b0;
    logic       RST;
    logic       hz_pc_WEN;
    logic [3:0] hz_pipe_stall;
    logic       hz_ifid_FLUSH, hz_idex_FLUSH, hz_exmem_FLUSH, hz_memwb_FLUSH;
    logic       fetch_valid, idex_Halt, memwb_Halt;

    logic        pc_en, dp_halt;
    logic [3:0]  stage_en, stage_clr, stage_valid;
    logic [31:0] stall_cnt, flush_cnt, retire_cnt;

    logic        pc_en4, dp_halt4;
    logic [3:0]  stage_en4, stage_clr4, stage_valid4;
    logic [3:0]  stall_cnt4, flush_cnt4, retire_cnt4;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    pipe_ctrl_seq #(.CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .hz_pc_WEN(hz_pc_WEN), .hz_pipe_stall(hz_pipe_stall),
        .hz_ifid_FLUSH(hz_ifid_FLUSH), .hz_idex_FLUSH(hz_idex_FLUSH),
        .hz_exmem_FLUSH(hz_exmem_FLUSH), .hz_memwb_FLUSH(hz_memwb_FLUSH),
        .fetch_valid(fetch_valid), .idex_Halt(idex_Halt), .memwb_Halt(memwb_Halt),
        .pc_en(pc_en), .stage_en(stage_en), .stage_clr(stage_clr),
        .stage_valid(stage_valid), .dp_halt(dp_halt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
    );

    pipe_ctrl_seq #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .hz_pc_WEN(hz_pc_WEN), .hz_pipe_stall(hz_pipe_stall),
        .hz_ifid_FLUSH(hz_ifid_FLUSH), .hz_idex_FLUSH(hz_idex_FLUSH),
        .hz_exmem_FLUSH(hz_exmem_FLUSH), .hz_memwb_FLUSH(hz_memwb_FLUSH),
        .fetch_valid(fetch_valid), .idex_Halt(idex_Halt), .memwb_Halt(memwb_Halt),
        .pc_en(pc_en4), .stage_en(stage_en4), .stage_clr(stage_clr4),
        .stage_valid(stage_valid4), .dp_halt(dp_halt4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4), .retire_cnt(retire_cnt4)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        hz_pc_WEN      = 1'b1;
        hz_pipe_stall  = 4'b0000;
        hz_ifid_FLUSH  = 1'b0;
        hz_idex_FLUSH  = 1'b0;
        hz_exmem_FLUSH = 1'b0;
        hz_memwb_FLUSH = 1'b0;
        fetch_valid    = 1'b0;
        idex_Halt      = 1'b0;
        memwb_Halt     = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        #1;
    endtask

    task automatic fill_pipe();
        fetch_valid = 1'b1;
        for (int k = 0; k < 4; k++) tick();
    endtask

    task automatic test_reset();
        apply_reset();
        // Run some traffic with stalls and flushes so there is state to clear.
        fetch_valid = 1'b1;
        tick(); tick();
        hz_pipe_stall = 4'b0010;
        hz_memwb_FLUSH = 1'b1;
        tick();
        hz_pipe_stall = 4'b0000;
        hz_memwb_FLUSH = 1'b0;
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        fetch_valid = 1'b0;
        #1;
        checks++; if (stage_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected %b", stage_valid, 4'b0000); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
        checks++; if (flush_cnt !== 32'd0) begin errors++; $display("FAIL reset_flush_cnt: got %0d expected 0", flush_cnt); end
        checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_retire_cnt: got %0d expected 0", retire_cnt); end
        checks++; if (dp_halt !== 1'b0) begin errors++; $display("FAIL reset_dp_halt: got %b expected 0", dp_halt); end
        checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL reset_state_run_pc_en: got %b expected 1", pc_en); end
    endtask

    task automatic test_straight_line();
        logic [3:0] exp_v;
        int n;
        apply_reset();
        fetch_valid = 1'b1;
        // First instruction lands in MEM/WB after edge 4 and retires on edge 5.
        for (int k = 1; k <= 11; k++) begin
            tick();
            n = (k < 4) ? k : 4;
            exp_v = 4'b1111 << (4 - n);
            checks++; if (stage_valid !== exp_v) begin errors++; $display("FAIL straight_valid[%0d]: got %b expected %b", k, stage_valid, exp_v); end
            checks++; if (retire_cnt !== 32'((k > 4) ? k - 4 : 0)) begin errors++; $display("FAIL straight_retire[%0d]: got %0d expected %0d", k, retire_cnt, (k > 4) ? k - 4 : 0); end
        end
        checks++; if (retire_cnt !== 32'd7) begin errors++; $display("FAIL straight_retire_final: got %0d expected 7", retire_cnt); end
        checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin errors++; $display("FAIL straight_no_stall_flush: got stall=%0d flush=%0d expected 0/0", stall_cnt, flush_cnt); end
    endtask

    task automatic test_load_use();
        apply_reset();
        fill_pipe();
        hz_pipe_stall = 4'b1000;
        hz_idex_FLUSH = 1'b1;
        hz_pc_WEN     = 1'b0;
        #1;
        checks++; if (stage_en !== 4'b0111) begin errors++; $display("FAIL loaduse_stage_en: got %b expected 0111", stage_en); end
        checks++; if (stage_clr !== 4'b0100) begin errors++; $display("FAIL loaduse_stage_clr: got %b expected 0100", stage_clr); end
        checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL loaduse_pc_en: got %b expected 0", pc_en); end
        tick();
        hz_pipe_stall = 4'b0000;
        hz_idex_FLUSH = 1'b0;
        hz_pc_WEN     = 1'b1;
        checks++; if (stage_valid !== 4'b1011) begin errors++; $display("FAIL loaduse_valid: got %b expected 1011", stage_valid); end
        checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL loaduse_stall_cnt: got %0d expected 1", stall_cnt); end
        checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL loaduse_flush_cnt: got %0d expected 1", flush_cnt); end
        tick();
        checks++; if (stage_valid !== 4'b1101) begin errors++; $display("FAIL loaduse_bubble_moves: got %b expected 1101", stage_valid); end
        checks++; if (retire_cnt !== 32'd2) begin errors++; $display("FAIL loaduse_retire: got %0d expected 2", retire_cnt); end
    endtask

    task automatic test_halt_drain();
        apply_reset();
        fill_pipe();
        idex_Halt = 1'b1;
        #1;
        checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL halt_pc_en_same_cycle: got %b expected 0", pc_en); end
        tick();
        idex_Halt = 1'b0;
        #1;
        checks++; if (stage_valid !== 4'b0111) begin errors++; $display("FAIL drain_valid1: got %b expected 0111", stage_valid); end
        checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL drain_pc_en: got %b expected 0", pc_en); end
        checks++; if (stage_en !== 4'b1111) begin errors++; $display("FAIL drain_stage_en: got %b expected 1111", stage_en); end
        tick();
        checks++; if (stage_valid !== 4'b0011) begin errors++; $display("FAIL drain_valid2: got %b expected 0011", stage_valid); end
        memwb_Halt = 1'b1;
        #1;
        checks++; if (dp_halt !== 1'b0) begin errors++; $display("FAIL drain_dp_halt_early: got %b expected 0", dp_halt); end
        tick();
        hz_pipe_stall = 4'b0000;
        hz_ifid_FLUSH = 1'b1;
        hz_exmem_FLUSH = 1'b1;
        #1;
        checks++; if (dp_halt !== 1'b1) begin errors++; $display("FAIL halted_dp_halt: got %b expected 1", dp_halt); end
        checks++; if (stage_en !== 4'b0000) begin errors++; $display("FAIL halted_stage_en: got %b expected 0000", stage_en); end
        checks++; if (stage_clr !== 4'b0000) begin errors++; $display("FAIL halted_stage_clr: got %b expected 0000", stage_clr); end
        checks++; if (stage_valid !== 4'b0001) begin errors++; $display("FAIL halted_valid: got %b expected 0001", stage_valid); end
        checks++; if (retire_cnt !== 32'd2) begin errors++; $display("FAIL halted_retire: got %0d expected 2", retire_cnt); end
        hz_pipe_stall = 4'b1111;
        for (int k = 0; k < 3; k++) tick();
        checks++; if (stage_valid !== 4'b0001 || dp_halt !== 1'b1) begin errors++; $display("FAIL halted_frozen: got valid=%b halt=%b expected 0001/1", stage_valid, dp_halt); end
        checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || retire_cnt !== 32'd2) begin errors++; $display("FAIL halted_counters_frozen: got %0d/%0d/%0d expected 0/0/2", stall_cnt, flush_cnt, retire_cnt); end
        apply_reset();
        checks++; if (dp_halt !== 1'b0 || pc_en !== 1'b1) begin errors++; $display("FAIL halted_reset_exit: got halt=%b pc_en=%b expected 0/1", dp_halt, pc_en); end
    endtask

    task automatic test_wrong_path_halt();
        apply_reset();
        fill_pipe();
        idex_Halt     = 1'b1;
        hz_idex_FLUSH = 1'b1;
        #1;
        checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL wrongpath_pc_en: got %b expected 1", pc_en); end
        tick();
        idex_Halt     = 1'b0;
        hz_idex_FLUSH = 1'b0;
        #1;
        checks++; if (pc_en !== 1'b1 || dp_halt !== 1'b0) begin errors++; $display("FAIL wrongpath_still_run: got pc_en=%b halt=%b expected 1/0", pc_en, dp_halt); end
        checks++; if (stage_valid !== 4'b1011) begin errors++; $display("FAIL wrongpath_valid: got %b expected 1011", stage_valid); end
        hz_pc_WEN = 1'b0;
        #1;
        checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL wrongpath_pc_follow: got %b expected 0", pc_en); end
        tick();
        checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL wrongpath_flush_cnt: got %0d expected 1", flush_cnt); end
    endtask

    task automatic test_saturation();
        apply_reset();
        hz_pipe_stall = 4'b1111;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 14) begin
                checks++; if (stall_cnt4 !== 4'hE) begin errors++; $display("FAIL sat_below_top: got %h expected e", stall_cnt4); end
            end
            if (k == 15) begin
                checks++; if (stall_cnt4 !== 4'hF) begin errors++; $display("FAIL sat_reach_top: got %h expected f", stall_cnt4); end
            end
        end
        checks++; if (stall_cnt4 !== 4'hF) begin errors++; $display("FAIL sat_no_wrap: got %h expected f", stall_cnt4); end
        checks++; if (stall_cnt !== 32'd20) begin errors++; $display("FAIL sat_wide_count: got %0d expected 20", stall_cnt); end
        hz_pipe_stall = 4'b0000;
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();
        test_reset();
        test_straight_line();
        test_load_use();
        test_halt_drain();
        test_wrong_path_halt();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
